// File: rtl/timer_pkg.sv
// Shared definitions for the programmable timer: FSM state encoding and mode values.
// Imported by timer_ctrl.
package timer_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'b00;
   localparam state_t ST_RUN  = 2'b01;
   localparam state_t ST_DONE = 2'b10;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/sync_counter_en.sv
// WIDTH-bit synchronous up-counter built from toggle stages on an AND carry chain.
// clr takes priority over en.
module sync_counter_en #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_toggle;

   // Stage gi toggles when enabled and every lower bit is 1.
   assign w_toggle[0] = en;
   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
         assign w_toggle[gi] = w_toggle[gi-1] & r_q[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else begin
         r_q <= r_q ^ w_toggle;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer: start/stop FSM, prescaler, shadowed period/mode and
// terminal compare driving a sync_counter_en datapath.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int PRESC_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               ack,
   input  logic               mode,
   input  logic [WIDTH-1:0]   period,
   input  logic [PRESC_W-1:0] presc,
   output logic               busy,
   output logic               done,
   output logic               tick,
   output logic [WIDTH-1:0]   count
);

   state_t             r_state;
   state_t             w_state_next;
   logic               r_mode;
   logic [WIDTH-1:0]   r_period;
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] r_pre;
   logic               r_tick;
   logic               r_busy;
   logic               r_done;

   logic               w_step;
   logic               w_term;
   logic               w_capture;
   logic               w_cnt_en;
   logic               w_cnt_clr;
   logic               w_tick_next;
   logic [WIDTH-1:0]   w_count;

   assign w_step = (r_pre == r_presc);
   assign w_term = (w_count == r_period);

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_cnt_en     = 1'b0;
      w_cnt_clr    = 1'b0;
      w_tick_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !stop) begin
               w_capture    = 1'b1;
               w_cnt_clr    = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            // stop outranks a terminal step arriving in the same cycle
            if (stop) begin
               w_cnt_clr    = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_step) begin
               if (!w_term) begin
                  w_cnt_en = 1'b1;
               end else begin
                  w_tick_next = 1'b1;
                  if (r_mode == MODE_PERIODIC) begin
                     w_cnt_clr = 1'b1;
                  end else begin
                     w_state_next = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            if (start) begin
               w_capture    = 1'b1;
               w_cnt_clr    = 1'b1;
               w_state_next = ST_RUN;
            end else if (ack) begin
               w_cnt_clr    = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_cnt_clr    = 1'b1;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_tick  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_tick  <= w_tick_next;
         r_busy  <= (w_state_next == ST_RUN);
         r_done  <= (w_state_next == ST_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if ((r_state == ST_RUN) && !stop && !w_step) begin
         r_pre <= r_pre + PRESC_W'(1);
      end else begin
         r_pre <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode   <= MODE_ONESHOT;
         r_period <= '0;
         r_presc  <= '0;
      end else if (w_capture) begin
         r_mode   <= mode;
         r_period <= period;
         r_presc  <= presc;
      end
   end

   sync_counter_en #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_cnt_en),
      .clr   (w_cnt_clr),
      .q     (w_count)
   );

   assign busy  = r_busy;
   assign done  = r_done;
   assign tick  = r_tick;
   assign count = w_count;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed and random checks of timer_ctrl against an elapsed-cycle reference model.
module tb_timer_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       ack;
   logic       mode;
   logic [3:0] period;
   logic [1:0] presc;
   logic       busy;
   logic       done;
   logic       tick;
   logic [3:0] count;

   int n_checks = 0;
   int n_errors = 0;
   int n_ticks  = 0;

   timer_ctrl #(.WIDTH(4), .PRESC_W(2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .stop   (stop),
      .ack    (ack),
      .mode   (mode),
      .period (period),
      .presc  (presc),
      .busy   (busy),
      .done   (done),
      .tick   (tick),
      .count  (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a run is described by elapsed RUN cycles e since the start edge.
   // Terminal every T=(N+1)*(P+1) cycles; count = e/(P+1).
   typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
   mst_t m_st;
   int   m_e, m_n, m_p, m_count;
   bit   m_mode, m_tick;

   function automatic void model_reset();
      m_st = M_IDLE; m_e = 0; m_n = 0; m_p = 0; m_mode = 1'b0;
      m_count = 0; m_tick = 1'b0;
   endfunction

   function automatic void model_capture();
      m_st = M_RUN; m_e = 0; m_count = 0;
      m_n = int'(period); m_p = int'(presc); m_mode = mode;
   endfunction

   function automatic void model_edge();
      int t;
      m_tick = 1'b0;
      case (m_st)
         M_IDLE: if (start && !stop) model_capture();
         M_RUN: begin
            if (stop) begin
               m_st = M_IDLE; m_count = 0;
            end else begin
               m_e++;
               t = (m_n + 1) * (m_p + 1);
               if (m_e == t) begin
                  m_tick = 1'b1;
                  if (m_mode) begin
                     m_e = 0; m_count = 0;
                  end else begin
                     m_st = M_DONE; m_count = m_n;
                  end
               end else begin
                  m_count = m_e / (m_p + 1);
               end
            end
         end
         M_DONE: begin
            if (start) model_capture();
            else if (ack) begin
               m_st = M_IDLE; m_count = 0;
            end
         end
         default: m_st = M_IDLE;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".busy"},  32'(busy),  32'(m_st == M_RUN));
      chk({tag, ".done"},  32'(done),  32'(m_st == M_DONE));
      chk({tag, ".tick"},  32'(tick),  32'(m_tick));
      chk({tag, ".count"}, 32'(count), 32'(m_count));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (tick === 1'b1) n_ticks++;
      chk_model(tag);
   endtask

   task automatic go(input logic m, input logic [3:0] n, input logic [1:0] p, input string tag);
      start = 1'b1; mode = m; period = n; presc = p;
      step(tag);
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
      mode = 1'b0; period = 4'd0; presc = 2'd0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk_model("reset");
      rst_n = 1'b1;
      step("idle");

      // 1: one-shot N=5 P=0
      go(1'b0, 4'd5, 2'd0, "t1_start");
      chk("t1_busy_c1", 32'(busy), 32'd1);
      repeat (6) step("t1_run");
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_hold5", 32'(count), 32'd5);
      step("t1_hold");
      ack = 1'b1; step("t1_ack"); ack = 1'b0;
      chk("t1_ack_cnt", 32'(count), 32'd0);

      // 2: periodic N=3 P=1, tick every 8
      n_ticks = 0;
      go(1'b1, 4'd3, 2'd1, "t2_start");
      repeat (24) step("t2_run");
      chk("t2_ticks", 32'(n_ticks), 32'd3);
      chk("t2_busy", 32'(busy), 32'd1);
      stop = 1'b1; step("t2_stop"); stop = 1'b0;

      // 3: periodic N=15 wraps, then N=0 ticks every cycle
      n_ticks = 0;
      go(1'b1, 4'd15, 2'd0, "t3_start");
      repeat (32) step("t3_run15");
      chk("t3_ticks15", 32'(n_ticks), 32'd2);
      stop = 1'b1; step("t3_stop"); stop = 1'b0;
      go(1'b1, 4'd0, 2'd0, "t3_start0");
      n_ticks = 0;
      repeat (5) step("t3_run0");
      chk("t3_ticks0", 32'(n_ticks), 32'd5);
      chk("t3_cnt0", 32'(count), 32'd0);
      stop = 1'b1; step("t3_stop0"); stop = 1'b0;

      // 4: stop mid-run, stop on terminal step, start+stop in IDLE
      go(1'b0, 4'd5, 2'd0, "t4a_start");
      repeat (2) step("t4a_run");
      chk("t4a_cnt2", 32'(count), 32'd2);
      stop = 1'b1; step("t4a_stop"); stop = 1'b0;
      chk("t4a_idle", 32'(busy), 32'd0);
      go(1'b0, 4'd3, 2'd0, "t4b_start");
      repeat (3) step("t4b_run");
      stop = 1'b1; step("t4b_stop_term"); stop = 1'b0;
      chk("t4b_no_tick", 32'(tick), 32'd0);
      start = 1'b1; stop = 1'b1; step("t4c_both"); start = 1'b0; stop = 1'b0;
      chk("t4c_stay_idle", 32'(busy), 32'd0);

      // 5: period change mid-run, restart from DONE, start during RUN ignored
      go(1'b0, 4'd5, 2'd0, "t5_start");
      repeat (2) step("t5_run");
      period = 4'd2;
      repeat (4) step("t5_run_chg");
      chk("t5_term5", 32'(count), 32'd5);
      start = 1'b1; step("t5_restart");
      chk("t5_done_clr", 32'(done), 32'd0);
      period = 4'd7;
      repeat (2) step("t5_start_in_run");
      start = 1'b0;
      step("t5_run2");
      chk("t5_term2", 32'(count), 32'd2);
      ack = 1'b1; step("t5_ack"); ack = 1'b0;

      // 6: async reset mid-run
      go(1'b0, 4'd8, 2'd0, "t6_start");
      repeat (3) step("t6_run");
      chk("t6_cnt3", 32'(count), 32'd3);
      #1 rst_n = 1'b0;
      model_reset();
      #1 chk_model("t6_async");
      #1 rst_n = 1'b1;
      repeat (4) step("t6_after");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         start  = ($urandom_range(0, 3) == 0);
         stop   = ($urandom_range(0, 15) == 0);
         ack    = ($urandom_range(0, 3) == 0);
         mode   = 1'($urandom_range(0, 1));
         period = 4'($urandom_range(0, 15));
         presc  = 2'($urandom_range(0, 3));
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
